vec_issue_queue: RTL and testbench

- Upstream feeder for the vector processing unit.
- Accepts 32-bit vector instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each instruction into the unit's command fields (enable, funct, vs1, vs2, vr, start_op), issues them one at a time, and pops each entry only after the unit returns op_done.
- Also owns the vector-length register that drives the unit's vl input.

---
 rtl/vec_issue_queue_if.sv | 24 ++
 rtl/vec_issue_queue.sv | 184 ++++++++++++++++++
 tb/tb_vec_issue_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vec_issue_queue_if.sv
// Instruction handshake and command bus between the issue queue and the vector unit.
// The slave modport is the queue side; the master modport is the feeder/unit side.
interface vec_issue_queue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        enable;
    logic [6:0]  funct;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vr;
    logic        start_op;
    logic        op_done;

    modport slave (
        input  instr_valid, instr, op_done,
        output instr_ready, enable, funct, vs1, vs2, vr, start_op
    );

    modport master (
        output instr_valid, instr, op_done,
        input  instr_ready, enable, funct, vs1, vs2, vr, start_op
    );
endinterface

// File: rtl/vec_issue_queue.sv
// Vector instruction issue queue: FIFO, decode, one-at-a-time issue and vl register.
// Optional macro VEC_ISSUE_TIMEOUT_EN adds a WAIT-state watchdog with output timeout_err.
module vec_issue_queue #(
    parameter int         DEPTH         = 4,
    parameter int         VECTOR_LENGTH = 4,
    parameter logic [6:0] VEC_OPCODE    = 7'h57
`ifdef VEC_ISSUE_TIMEOUT_EN
    , parameter int       TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    vec_issue_queue_if.slave             bus,
    input  logic                         vl_wr_en,
    input  logic [31:0]                  vl_wr_data,
    output logic [31:0]                  vl,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         illegal_instr,
    output logic                         cfg_err
`ifdef VEC_ISSUE_TIMEOUT_EN
    , output logic                       timeout_err
`endif
);
    localparam int          CW     = $clog2(DEPTH + 1);
    localparam int          PW     = $clog2(DEPTH);
    localparam logic [31:0] VL_MAX = 32'(VECTOR_LENGTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [21:0]     mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [21:0]     head_s;
    logic            ready_s;
    logic            xfer_s;
    logic            push_s;
    logic            pop_s;
    logic            enable_r;
    logic [6:0]      funct_r;
    logic [4:0]      vs1_r;
    logic [4:0]      vs2_r;
    logic [4:0]      vr_r;
    logic            start_op_r;
    logic [31:0]     vl_r;
    logic            illegal_r;
    logic            cfg_err_r;
    logic            unused_bits_s;
`ifdef VEC_ISSUE_TIMEOUT_EN
    localparam int   TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   tcnt_r;
    logic            tout_s;
    logic            timeout_err_r;
`endif

    assign ready_s       = (count_r < CW'(DEPTH));
    assign xfer_s        = bus.instr_valid && ready_s;
    assign push_s        = xfer_s && (bus.instr[6:0] == VEC_OPCODE);
    assign head_s        = mem_r[rd_ptr_r];
    assign unused_bits_s = ^bus.instr[14:12];

    // Next-state decode; pop happens only when the in-flight op retires.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
`ifdef VEC_ISSUE_TIMEOUT_EN
        tout_s  = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (count_r != '0) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (bus.op_done) begin
                    pop_s   = 1'b1;
                    state_s = IDLE;
                end
`ifdef VEC_ISSUE_TIMEOUT_EN
                else if (tcnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                    pop_s   = 1'b1;
                    tout_s  = 1'b1;
                    state_s = IDLE;
                end
`endif
                else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FIFO storage holds only the decoded command fields.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.instr[31:25], bus.instr[24:20], bus.instr[19:15], bus.instr[11:7]};
        end
    end

    // Control state, FIFO pointers, command outputs and vl register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            enable_r   <= 1'b0;
            funct_r    <= 7'd0;
            vs1_r      <= 5'd0;
            vs2_r      <= 5'd0;
            vr_r       <= 5'd0;
            start_op_r <= 1'b0;
            vl_r       <= VL_MAX;
            illegal_r  <= 1'b0;
            cfg_err_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (state_r == IDLE && count_r != '0) begin
                {funct_r, vs2_r, vs1_r, vr_r} <= head_s;
                enable_r <= 1'b1;
            end else if (pop_s) begin
                enable_r <= 1'b0;
            end
            start_op_r <= (state_r == ISSUE);
            illegal_r  <= xfer_s && !push_s;
            cfg_err_r  <= vl_wr_en && (state_r != IDLE);
            // A write on the IDLE->ISSUE edge still lands, so the new op sees it.
            if (vl_wr_en && state_r == IDLE) begin
                vl_r <= (vl_wr_data > VL_MAX) ? VL_MAX : vl_wr_data;
            end
        end
    end

`ifdef VEC_ISSUE_TIMEOUT_EN
    // Watchdog counts WAIT cycles without op_done; op_done on the terminal count wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_r        <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            if (state_r == ISSUE) begin
                tcnt_r <= '0;
            end else if (state_r == WAIT && !bus.op_done) begin
                tcnt_r <= tcnt_r + TW'(1);
            end
            timeout_err_r <= tout_s;
        end
    end

    assign timeout_err = timeout_err_r;
`endif

    assign bus.instr_ready = ready_s;
    assign bus.enable      = enable_r;
    assign bus.funct       = funct_r;
    assign bus.vs1         = vs1_r;
    assign bus.vs2         = vs2_r;
    assign bus.vr          = vr_r;
    assign bus.start_op    = start_op_r;
    assign vl              = vl_r;
    assign count           = count_r;
    assign busy            = (state_r != IDLE);
    assign illegal_instr   = illegal_r;
    assign cfg_err         = cfg_err_r;
endmodule

// File: tb/tb_vec_issue_queue.sv
// Directed self-checking bench for vec_issue_queue (timeout section built when VEC_ISSUE_TIMEOUT_EN is set).
module tb_vec_issue_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        vl_wr_en;
    logic [31:0] vl_wr_data;
    logic [31:0] vl;
    logic [2:0]  count;
    logic        busy;
    logic        illegal_instr;
    logic        cfg_err;
    int          total = 0;
    int          bad   = 0;

    vec_issue_queue_if bus ();

    always #5 clk = ~clk;

`ifdef VEC_ISSUE_TIMEOUT_EN
    logic timeout_err;
    vec_issue_queue #(.DEPTH(4), .VECTOR_LENGTH(4), .VEC_OPCODE(7'h57), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .vl_wr_en(vl_wr_en), .vl_wr_data(vl_wr_data),
        .vl(vl), .count(count), .busy(busy), .illegal_instr(illegal_instr), .cfg_err(cfg_err),
        .timeout_err(timeout_err)
    );
`else
    vec_issue_queue #(.DEPTH(4), .VECTOR_LENGTH(4), .VEC_OPCODE(7'h57)) dut (
        .clk(clk), .rst(rst), .bus(bus), .vl_wr_en(vl_wr_en), .vl_wr_data(vl_wr_data),
        .vl(vl), .count(count), .busy(busy), .illegal_instr(illegal_instr), .cfg_err(cfg_err)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // funct=k+4, vs2=k+1, vs1=k+2, vr=k+7, vector opcode
    function automatic logic [31:0] word(input int k);
        return {7'(k + 4), 5'(k + 1), 5'(k + 2), 3'b000, 5'(k + 7), 7'h57};
    endfunction

    initial begin
        rst = 1'b1; vl_wr_en = 1'b0; vl_wr_data = 32'd0;
        bus.instr_valid = 1'b0; bus.instr = 32'd0; bus.op_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_enable", 32'(bus.enable), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_start",  32'(bus.start_op), 32'd0);
        chk("rst_funct",  32'(bus.funct), 32'd0);
        chk("rst_vl",     vl, 32'd4);
        chk("rst_ready",  32'(bus.instr_ready), 32'd1);

        // single op
        bus.instr_valid = 1'b1; bus.instr = 32'h0231_0557;
        tick();
        bus.instr_valid = 1'b0;
        chk("s_count1", 32'(count), 32'd1);
        chk("s_en_e0",  32'(bus.enable), 32'd0);
        tick();
        chk("s_busy_e1",  32'(busy), 32'd1);
        chk("s_en_e1",    32'(bus.enable), 32'd1);
        chk("s_start_e1", 32'(bus.start_op), 32'd0);
        chk("s_fields",   {15'd0, bus.funct, bus.vs1, bus.vs2, bus.vr}, {15'd0, 7'd1, 5'd2, 5'd3, 5'd10});
        tick();
        chk("s_start_e2", 32'(bus.start_op), 32'd1);
        tick();
        chk("s_start_off", 32'(bus.start_op), 32'd0);
        chk("s_en_wait",   32'(bus.enable), 32'd1);
        tick();
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        chk("s_count0", 32'(count), 32'd0);
        chk("s_en_off", 32'(bus.enable), 32'd0);
        chk("s_idle",   32'(busy), 32'd0);
        tick();
        chk("s_no_reissue", 32'({busy, bus.start_op}), 32'd0);

        // illegal opcode
        bus.instr_valid = 1'b1; bus.instr = 32'h0000_0033;
        chk("il_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        bus.instr_valid = 1'b0;
        chk("il_pulse", 32'(illegal_instr), 32'd1);
        chk("il_count", 32'(count), 32'd0);
        tick();
        chk("il_pulse_end", 32'(illegal_instr), 32'd0);
        tick();
        chk("il_no_issue", 32'({busy, bus.start_op}), 32'd0);

        // vl writes in IDLE, with clamp
        vl_wr_en = 1'b1; vl_wr_data = 32'd2;
        tick();
        chk("vl_two", vl, 32'd2);
        vl_wr_data = 32'd9;
        tick();
        vl_wr_en = 1'b0;
        chk("vl_clamp", vl, 32'd4);
        chk("vl_no_err", 32'(cfg_err), 32'd0);

        // fill and stall; vl write coinciding with IDLE->ISSUE
        bus.instr_valid = 1'b1; bus.instr = word(0);
        tick();
        bus.instr = word(1); vl_wr_en = 1'b1; vl_wr_data = 32'd3;
        tick();
        vl_wr_en = 1'b0;
        chk("f_vl_issue_edge", vl, 32'd3);
        chk("f_busy", 32'(busy), 32'd1);
        bus.instr = word(2);
        tick();
        chk("f_start", 32'(bus.start_op), 32'd1);
        chk("f_funct0", 32'(bus.funct), 32'd4);
        bus.instr = word(3);
        tick();
        chk("f_full", 32'(count), 32'd4);
        chk("f_ready0", 32'(bus.instr_ready), 32'd0);
        bus.instr = word(4);
        tick();
        chk("f_stall", 32'(count), 32'd4);
        vl_wr_en = 1'b1; vl_wr_data = 32'd2;
        tick();
        vl_wr_en = 1'b0;
        chk("f_cfg_err", 32'(cfg_err), 32'd1);
        chk("f_vl_kept", vl, 32'd3);
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        chk("f_pop", 32'(count), 32'd3);
        chk("f_ready1", 32'(bus.instr_ready), 32'd1);
        chk("f_bubble", 32'({busy, bus.enable}), 32'd0);
        chk("f_cfg_end", 32'(cfg_err), 32'd0);
        tick();
        bus.instr_valid = 1'b0;
        chk("f_5th_acc", 32'(count), 32'd4);
        chk("f_issue1", {25'd0, bus.funct}, 32'd5);
        chk("f_start_lat", 32'(bus.start_op), 32'd0);
        tick();
        chk("f_start1", 32'(bus.start_op), 32'd1);
        chk("f_vs1_1", 32'(bus.vs1), 32'd3);
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        tick(); tick();
        chk("r_pre_count", 32'(count), 32'd3);
        chk("r_pre_busy", 32'(busy), 32'd1);
        chk("r_pre_funct", 32'(bus.funct), 32'd6);

        // reset mid-op
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_count", 32'(count), 32'd0);
        chk("r_state", 32'({busy, bus.enable, bus.start_op}), 32'd0);
        chk("r_vl", vl, 32'd4);
        bus.op_done = 1'b1;
        tick();
        bus.op_done = 1'b0;
        chk("r_late_done", 32'(count), 32'd0);
        chk("r_late_busy", 32'(busy), 32'd0);

`ifdef VEC_ISSUE_TIMEOUT_EN
        // timeout with TIMEOUT_CYCLES=8
        bus.instr_valid = 1'b1; bus.instr = word(0);
        tick();
        bus.instr = word(1);
        tick();
        bus.instr_valid = 1'b0;
        tick();
        chk("t_start", 32'(bus.start_op), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t_quiet", 32'({timeout_err, busy}), 32'd1);
        end
        tick();
        chk("t_pulse", 32'(timeout_err), 32'd1);
        chk("t_pop", 32'(count), 32'd1);
        chk("t_en_off", 32'(bus.enable), 32'd0);
        tick();
        chk("t_pulse_end", 32'(timeout_err), 32'd0);
        chk("t_next", {25'd0, bus.funct}, 32'd5);
        chk("t_next_en", 32'(bus.enable), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
